pif_to_posit_stage: RTL

PIF_TO_POSIT_STAGE -- requirements
Module: pif_to_posit_stage

---
 rtl/pif_to_posit_stage_if.sv | 55 +++++
 rtl/pif_to_posit_stage.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pif_to_posit_stage_if.sv
// pif_to_posit_stage_if
//   Bundles the upstream (pif word) and downstream (posit) handshakes of
//   pif_to_posit_stage.
//   slave  : the conversion stage (consumes pif words, produces posits)
//   master : the producer/consumer environment around the stage
//   Signals:
//     in_valid / in_ready      upstream handshake
//     in_pif                   {sign, exp (signed, unbiased), frac}
//     in_is_zero / in_is_nar   special-value overrides (nar wins)
//     out_valid / out_ready    downstream handshake
//     out_posit                encoded N-bit posit
interface pif_to_posit_stage_if #(
  parameter int N     = 16,
  parameter int FSIZE = 64
);
  function automatic int float_exp_size_f(input int fs);
    case (fs)
      16:      return 5;
      32:      return 8;
      64:      return 11;
      default: return 15;
    endcase
  endfunction

  function automatic int float_mant_size_f(input int fs);
    case (fs)
      16:      return 10;
      32:      return 23;
      64:      return 52;
      default: return fs - 16;
    endcase
  endfunction

  localparam int EW = float_exp_size_f(FSIZE);
  localparam int MW = float_mant_size_f(FSIZE);

  logic              in_valid;
  logic              in_ready;
  logic [EW+MW:0]    in_pif;
  logic              in_is_zero;
  logic              in_is_nar;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      out_posit;

  modport slave (
    input  in_valid, in_pif, in_is_zero, in_is_nar, out_ready,
    output in_ready, out_valid, out_posit
  );

  modport master (
    output in_valid, in_pif, in_is_zero, in_is_nar, out_ready,
    input  in_ready, out_valid, out_posit
  );
endinterface

// File: rtl/pif_to_posit_stage.sv
// pif_to_posit_stage
//   Two-register pipeline converting an unpacked float (pif) word into an
//   N-bit posit with ES exponent bits, round-to-nearest-even.
//   S1: regime/exponent/fraction packed into an N-1 bit magnitude plus
//       guard and sticky bits, and the special-value flags.
//   S2: rounding, saturation, sign application and specials.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  pif_to_posit_stage_if.slave (both handshakes and data)
module pif_to_posit_stage #(
  parameter int N     = 16,
  parameter int ES    = 1,
  parameter int FSIZE = 64
) (
  input logic                  clk,
  input logic                  rst,
  pif_to_posit_stage_if.slave  bus
);
  function automatic int float_exp_size_f(input int fs);
    case (fs)
      16:      return 5;
      32:      return 8;
      64:      return 11;
      default: return 15;
    endcase
  endfunction

  function automatic int float_mant_size_f(input int fs);
    case (fs)
      16:      return 10;
      32:      return 23;
      64:      return 52;
      default: return fs - 16;
    endcase
  endfunction

  localparam int EW = float_exp_size_f(FSIZE);
  localparam int MW = float_mant_size_f(FSIZE);
  // Regime seed (2) + e + frac + N pad bits: the largest regime shift is
  // N-2, so every fraction bit survives into the guard/sticky window.
  localparam int W  = N + ES + MW + 2;
  localparam logic [N-2:0] MINPOS = {{(N-2){1'b0}}, 1'b1};

  // Pipeline state
  logic           s1_valid_reg, s1_sign_reg, s1_zero_reg, s1_nar_reg;
  logic [N-2:0]   s1_mag_reg;
  logic           s1_g_reg, s1_s_reg;
  logic           s2_valid_reg;
  logic [N-1:0]   s2_posit_reg;
  logic           init_done_reg;

  logic           s1_en, s2_en, in_accept;

  // Handshake: ready ripples combinationally back from out_ready
  assign s2_en         = !s2_valid_reg || bus.out_ready;
  assign s1_en         = !s1_valid_reg || s2_en;
  assign bus.in_ready  = s1_en && init_done_reg;
  assign in_accept     = bus.in_valid && bus.in_ready;
  assign bus.out_valid = s2_valid_reg;
  assign bus.out_posit = s2_posit_reg;

  // ---------------- S1 decode ----------------
  logic signed [EW-1:0] exp_s, k;
  logic [ES-1:0]        e_d;
  logic [MW-1:0]        frac_d;
  logic [W-1:0]         seed, shifted;
  logic [N-2:0]         mag_d;
  logic                 g_d, s_d;
  int                   k_int, sh;

  always_comb begin
    exp_s  = $signed(bus.in_pif[MW +: EW]);
    frac_d = bus.in_pif[MW-1:0];
    k      = exp_s >>> ES;          // floor(exp / 2^ES)
    e_d    = exp_s[ES-1:0];
    k_int  = int'(k);
    // k>=0: seed "10" arithmetic-shifted by k gives k+1 ones then a 0.
    // k<0 : seed "01" logically shifted by -k-1 gives -k zeros then a 1.
    if (k_int >= 0) begin
      seed = {2'b10, e_d, frac_d, {N{1'b0}}};
      sh   = k_int;
    end else begin
      seed = {2'b01, e_d, frac_d, {N{1'b0}}};
      sh   = -k_int - 1;
    end
    if (sh > N) sh = N;             // saturated cases are overridden below
    if (k_int >= 0) shifted = $signed(seed) >>> sh;
    else            shifted = seed >> sh;
    mag_d = shifted[W-1 -: N-1];
    g_d   = shifted[W-N];
    s_d   = |shifted[W-N-1:0];
    if (k_int > N-2) begin
      mag_d = '1;
      g_d   = 1'b0;
      s_d   = 1'b0;
    end else if (k_int < -(N-2)) begin
      mag_d = MINPOS;
      g_d   = 1'b0;
      s_d   = 1'b0;
    end
  end

  // ---------------- S2 round / encode ----------------
  logic           inc;
  logic [N-1:0]   sum_d, posit_d;
  logic [N-2:0]   mag_r;

  always_comb begin
    inc   = s1_g_reg && (s1_s_reg || s1_mag_reg[0]);
    sum_d = {1'b0, s1_mag_reg} + {{(N-1){1'b0}}, inc};
    // Carry out of the magnitude means maxpos was incremented: clamp.
    mag_r = sum_d[N-1] ? {(N-1){1'b1}} : sum_d[N-2:0];
    if (mag_r == '0) mag_r = MINPOS;   // nonzero input never encodes to 0
    posit_d = s1_sign_reg ? (~{1'b0, mag_r} + {{(N-1){1'b0}}, 1'b1})
                          : {1'b0, mag_r};
    if (s1_nar_reg)       posit_d = {1'b1, {(N-1){1'b0}}};
    else if (s1_zero_reg) posit_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_done_reg <= 1'b0;
      s1_valid_reg  <= 1'b0;
      s1_sign_reg   <= 1'b0;
      s1_zero_reg   <= 1'b0;
      s1_nar_reg    <= 1'b0;
      s1_mag_reg    <= '0;
      s1_g_reg      <= 1'b0;
      s1_s_reg      <= 1'b0;
      s2_valid_reg  <= 1'b0;
      s2_posit_reg  <= '0;
    end else begin
      init_done_reg <= 1'b1;
      if (s1_en) begin
        s1_valid_reg <= in_accept;
        if (in_accept) begin
          s1_sign_reg <= bus.in_pif[EW+MW];
          s1_zero_reg <= bus.in_is_zero;
          s1_nar_reg  <= bus.in_is_nar;
          s1_mag_reg  <= mag_d;
          s1_g_reg    <= g_d;
          s1_s_reg    <= s_d;
        end
      end
      if (s2_en) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) s2_posit_reg <= posit_d;
      end
    end
  end
endmodule
